// File: rtl/multicycle_control.sv
// Control unit for a multicycle RISC-V style datapath. It walks each instruction
// through FETCH/DECODE/EXEC/MEM/WB and counts retired instructions.
module multicycle_control #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [6:0]       Op_i,
    input  logic             mem_ready_i,
    output logic             PCWrite_o,
    output logic             IRWrite_o,
    output logic             MemRead_o,
    output logic             MemWrite_o,
    output logic             RegWrite_o,
    output logic             MemtoReg_o,
    output logic             Branch_o,
    output logic [1:0]       ALUOp_o,
    output logic             ALUSrcA_o,
    output logic [1:0]       ALUSrcB_o,
    output logic [2:0]       state_o,
    output logic             instr_done_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] instr_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_BAD    = 3'd7
    } state_t;

    localparam logic [6:0] OP_R  = 7'd51;
    localparam logic [6:0] OP_I  = 7'd19;
    localparam logic [6:0] OP_LD = 7'd3;
    localparam logic [6:0] OP_ST = 7'd35;
    localparam logic [6:0] OP_BR = 7'd99;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // fetch and mem_store mark the states whose strobes are qualified by mem_ready_i
    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       branch;
        logic       done;
        logic       alu_src_a;
        logic [1:0] alu_op;
        logic [1:0] alu_src_b;
        logic       fetch;
        logic       mem_store;
    } ctrl_t;

    function automatic ctrl_t decode_ctrl(input state_t st, input logic [6:0] op);
        ctrl_t c;
        c = '0;
        case (st)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = 2'b01;
                c.fetch     = 1'b1;
            end
            S_EXEC: begin
                c.alu_src_a = 1'b1;
                case (op)
                    OP_R:  c.alu_op = 2'b10;
                    OP_I: begin
                        c.alu_op    = 2'b11;
                        c.alu_src_b = 2'b10;
                    end
                    OP_LD, OP_ST: c.alu_src_b = 2'b10;
                    OP_BR: begin
                        c.alu_op = 2'b01;
                        c.branch = 1'b1;
                        c.done   = 1'b1;
                    end
                    default: c.alu_src_a = 1'b1;
                endcase
            end
            S_MEM: begin
                case (op)
                    OP_LD: c.mem_read = 1'b1;
                    OP_ST: begin
                        c.mem_write = 1'b1;
                        c.mem_store = 1'b1;
                    end
                    default: c.mem_read = 1'b0;
                endcase
            end
            S_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = (op == OP_LD);
                c.done       = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    state_t           state_r, state_nx_s;
    logic [6:0]       opcode_r, opcode_nx_s;
    ctrl_t            ctrl_r;
    logic             illegal_r;
    logic [CNT_W-1:0] cnt_r;
    logic             instr_done_s;

    // Next-state and opcode-latch selection
    always_comb begin
        state_nx_s  = state_r;
        opcode_nx_s = opcode_r;
        case (state_r)
            S_IDLE: begin
                if (start_i) state_nx_s = S_FETCH;
                else         state_nx_s = S_IDLE;
            end
            S_FETCH: begin
                if (mem_ready_i) state_nx_s = S_DECODE;
                else             state_nx_s = S_FETCH;
            end
            S_DECODE: begin
                opcode_nx_s = Op_i;
                case (Op_i)
                    OP_R, OP_I, OP_LD, OP_ST, OP_BR: state_nx_s = S_EXEC;
                    default:                         state_nx_s = S_HALT;
                endcase
            end
            S_EXEC: begin
                case (opcode_r)
                    OP_R, OP_I:   state_nx_s = S_WB;
                    OP_LD, OP_ST: state_nx_s = S_MEM;
                    OP_BR:        state_nx_s = S_FETCH;
                    default:      state_nx_s = S_HALT;
                endcase
            end
            S_MEM: begin
                if (mem_ready_i) state_nx_s = (opcode_r == OP_LD) ? S_WB : S_FETCH;
                else             state_nx_s = S_MEM;
            end
            S_WB:    state_nx_s = S_FETCH;
            S_HALT:  state_nx_s = S_HALT;
            default: state_nx_s = S_IDLE;
        endcase
    end

    // State, opcode, registered control word, sticky illegal flag and retire counter
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_r   <= S_IDLE;
            opcode_r  <= 7'd0;
            ctrl_r    <= '0;
            illegal_r <= 1'b0;
            cnt_r     <= '0;
        end else begin
            state_r   <= state_nx_s;
            opcode_r  <= opcode_nx_s;
            ctrl_r    <= decode_ctrl(state_nx_s, opcode_nx_s);
            illegal_r <= illegal_r | (state_nx_s == S_HALT);
            if (instr_done_s) cnt_r <= cnt_r + CNT_ONE;
            else              cnt_r <= cnt_r;
        end
    end

    // IR/PC write and store retire happen in the very cycle memory reports ready
    assign instr_done_s = ctrl_r.done | (ctrl_r.mem_store & mem_ready_i);

    assign PCWrite_o    = ctrl_r.fetch & mem_ready_i;
    assign IRWrite_o    = ctrl_r.fetch & mem_ready_i;
    assign MemRead_o    = ctrl_r.mem_read;
    assign MemWrite_o   = ctrl_r.mem_write;
    assign RegWrite_o   = ctrl_r.reg_write;
    assign MemtoReg_o   = ctrl_r.mem_to_reg;
    assign Branch_o     = ctrl_r.branch;
    assign ALUOp_o      = ctrl_r.alu_op;
    assign ALUSrcA_o    = ctrl_r.alu_src_a;
    assign ALUSrcB_o    = ctrl_r.alu_src_b;
    assign state_o      = state_r;
    assign instr_done_o = instr_done_s;
    assign illegal_o    = illegal_r;
    assign instr_cnt_o  = cnt_r;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench: per-cycle expected traces are generated from instruction
// descriptions (opcode, wait cycles) and applied/compared in one loop.
module tb_multicycle_control;

    localparam int CW = 4;

    logic          clk_i = 1'b0;
    logic          rst_i, start_i, mem_ready_i;
    logic [6:0]    Op_i;
    logic          PCWrite_o, IRWrite_o, MemRead_o, MemWrite_o, RegWrite_o;
    logic          MemtoReg_o, Branch_o, ALUSrcA_o, instr_done_o, illegal_o;
    logic [1:0]    ALUOp_o, ALUSrcB_o;
    logic [2:0]    state_o;
    logic [CW-1:0] instr_cnt_o;

    multicycle_control #(.CNT_W(CW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .Op_i(Op_i),
        .mem_ready_i(mem_ready_i), .PCWrite_o(PCWrite_o), .IRWrite_o(IRWrite_o),
        .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o), .RegWrite_o(RegWrite_o),
        .MemtoReg_o(MemtoReg_o), .Branch_o(Branch_o), .ALUOp_o(ALUOp_o),
        .ALUSrcA_o(ALUSrcA_o), .ALUSrcB_o(ALUSrcB_o), .state_o(state_o),
        .instr_done_o(instr_done_o), .illegal_o(illegal_o), .instr_cnt_o(instr_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    localparam logic [6:0] R = 7'd51, I = 7'd19, LD = 7'd3, ST = 7'd35, BR = 7'd99;
    // enable vector order: {PCWrite, IRWrite, MemRead, MemWrite, RegWrite, MemtoReg, Branch}
    localparam logic [6:0] E_NONE = 7'b0000000, E_FWAIT = 7'b0010000, E_FRDY = 7'b1110000;
    localparam logic [6:0] E_RD = 7'b0010000, E_WR = 7'b0001000, E_WB = 7'b0000100;
    localparam logic [6:0] E_WBLD = 7'b0000110, E_BR = 7'b0000001;

    typedef struct {
        logic        rst;
        logic        start;
        logic [6:0]  op;
        logic        mr;
        bit          chk;
        logic [20:0] exp;
    } vec_t;

    vec_t vq[$];
    int   lat_q[$];
    int   m_cnt = 0;
    logic m_ill = 1'b0;
    int   total = 0;
    int   bad   = 0;

    function automatic logic [15:0] mk(input logic [2:0] st, input logic [6:0] en,
                                       input logic [1:0] aop, input logic sa,
                                       input logic [1:0] sb, input logic dn);
        return {st, en, aop, sa, sb, dn};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [6:0] ro();
        return 7'($urandom_range(0, 127));
    endfunction

    function automatic bit legal(input logic [6:0] op);
        return (op == R) || (op == I) || (op == LD) || (op == ST) || (op == BR);
    endfunction

    task automatic push(input logic rst, input logic start, input logic [6:0] op,
                        input logic mr, input bit chk, input logic [15:0] o);
        vec_t v;
        v.rst = rst; v.start = start; v.op = op; v.mr = mr; v.chk = chk;
        v.exp = {o, m_ill, 4'(m_cnt)};
        vq.push_back(v);
    endtask

    task automatic retire();
        m_cnt = (m_cnt + 1) % 16;
    endtask

    task automatic model_reset_and_start();
        m_cnt = 0;
        m_ill = 1'b0;
        push(1'b1, 1'b1, ro(), rb(), 1'b1, mk(3'd0, E_NONE, 2'b00, 1'b0, 2'b00, 1'b0));
    endtask

    // One instruction from FETCH entry; fw/mw are memory wait cycles in FETCH/MEM
    task automatic gen_instr(input logic [6:0] op, input int fw, input int mw, input bit rst_mem);
        logic [1:0] aop, sb;
        logic [6:0] en;
        for (int k = 0; k < fw; k++)
            push(1'b1, rb(), ro(), 1'b0, 1'b1, mk(3'd1, E_FWAIT, 2'b00, 1'b0, 2'b01, 1'b0));
        push(1'b1, rb(), ro(), 1'b1, 1'b1, mk(3'd1, E_FRDY, 2'b00, 1'b0, 2'b01, 1'b0));
        push(1'b1, rb(), op, rb(), 1'b1, mk(3'd2, E_NONE, 2'b00, 1'b0, 2'b00, 1'b0));
        if (!legal(op)) begin
            m_ill = 1'b1;
            for (int k = 0; k < 3; k++)
                push(1'b1, 1'b1, ro(), rb(), 1'b1, mk(3'd6, E_NONE, 2'b00, 1'b0, 2'b00, 1'b0));
            push(1'b0, 1'b1, ro(), rb(), 1'b1, mk(3'd6, E_NONE, 2'b00, 1'b0, 2'b00, 1'b0));
            model_reset_and_start();
            return;
        end
        aop = (op == R) ? 2'b10 : (op == I) ? 2'b11 : (op == BR) ? 2'b01 : 2'b00;
        sb  = (op == R || op == BR) ? 2'b00 : 2'b10;
        push(1'b1, rb(), ro(), rb(), 1'b1,
             mk(3'd3, (op == BR) ? E_BR : E_NONE, aop, 1'b1, sb, op == BR));
        if (op == BR) begin
            retire();
            lat_q.push_back(3 + fw);
            return;
        end
        if (op == LD || op == ST) begin
            en = (op == LD) ? E_RD : E_WR;
            if (rst_mem) begin
                push(1'b0, rb(), ro(), 1'b0, 1'b1, mk(3'd4, en, 2'b00, 1'b0, 2'b00, 1'b0));
                model_reset_and_start();
                return;
            end
            for (int k = 0; k < mw; k++)
                push(1'b1, rb(), ro(), 1'b0, 1'b1, mk(3'd4, en, 2'b00, 1'b0, 2'b00, 1'b0));
            push(1'b1, rb(), ro(), 1'b1, 1'b1, mk(3'd4, en, 2'b00, 1'b0, 2'b00, op == ST));
            if (op == ST) begin
                retire();
                lat_q.push_back(4 + fw + mw);
                return;
            end
        end
        push(1'b1, rb(), ro(), rb(), 1'b1,
             mk(3'd5, (op == LD) ? E_WBLD : E_WB, 2'b00, 1'b0, 2'b00, 1'b1));
        retire();
        lat_q.push_back(((op == LD) ? 5 + mw : 4) + fw);
    endtask

    logic [20:0] act;
    logic [2:0]  prev_state;
    int          fetch_idx;
    int          want_lat;

    initial begin
        logic [6:0] op;
        rst_i = 1'b0; start_i = 1'b0; Op_i = 7'd0; mem_ready_i = 1'b0;

        // Reset, idle without start, then one R-type with memory always ready
        push(1'b0, 1'b1, 7'h33, 1'b1, 1'b0, 16'h0000);
        push(1'b1, 1'b0, 7'h33, 1'b1, 1'b1, mk(3'd0, E_NONE, 2'b00, 1'b0, 2'b00, 1'b0));
        push(1'b1, 1'b1, 7'h63, 1'b1, 1'b1, mk(3'd0, E_NONE, 2'b00, 1'b0, 2'b00, 1'b0));
        push(1'b1, 1'b0, 7'h03, 1'b1, 1'b1, mk(3'd1, E_FRDY, 2'b00, 1'b0, 2'b01, 1'b0));
        push(1'b1, 1'b1, 7'd51, 1'b1, 1'b1, mk(3'd2, E_NONE, 2'b00, 1'b0, 2'b00, 1'b0));
        push(1'b1, 1'b1, 7'h23, 1'b1, 1'b1, mk(3'd3, E_NONE, 2'b10, 1'b1, 2'b00, 1'b0));
        push(1'b1, 1'b0, 7'h7F, 1'b1, 1'b1, mk(3'd5, E_WB, 2'b00, 1'b0, 2'b00, 1'b1));
        m_cnt = 1;
        lat_q.push_back(4);

        // Multi-cycle corner cases
        gen_instr(LD, 2, 1, 1'b0);
        gen_instr(ST, 0, 2, 1'b0);
        gen_instr(BR, 0, 0, 1'b0);
        gen_instr(I, 1, 0, 1'b0);
        gen_instr(ST, 0, 1, 1'b1);
        gen_instr(7'h7F, 0, 0, 1'b0);
        for (int k = 0; k < 16; k++) gen_instr(R, 0, 0, 1'b0);

        // Randomized instruction stream
        for (int k = 0; k < 150; k++) begin
            case ($urandom_range(0, 5))
                0: op = R;
                1: op = I;
                2: op = LD;
                3: op = ST;
                4: op = BR;
                default: op = ($urandom_range(0, 3) == 0) ? 7'h7F : LD;
            endcase
            if (op == 7'h7F) begin
                do op = ro(); while (legal(op));
            end
            gen_instr(op, $urandom_range(0, 2), $urandom_range(0, 2),
                      (op == LD || op == ST) && ($urandom_range(0, 14) == 0));
        end

        prev_state = 3'd0;
        fetch_idx  = 0;
        for (int i = 0; i < vq.size(); i++) begin
            @(posedge clk_i);
            #1;
            rst_i = vq[i].rst; start_i = vq[i].start; Op_i = vq[i].op; mem_ready_i = vq[i].mr;
            #3;
            if (vq[i].chk) begin
                act = {state_o, PCWrite_o, IRWrite_o, MemRead_o, MemWrite_o, RegWrite_o,
                       MemtoReg_o, Branch_o, ALUOp_o, ALUSrcA_o, ALUSrcB_o, instr_done_o,
                       illegal_o, instr_cnt_o};
                total++;
                if (act !== vq[i].exp) begin
                    bad++;
                    $display("FAIL vec[%0d] outputs got=%h want=%h (state,en,aluop,srca,srcb,done,ill,cnt)",
                             i, act, vq[i].exp);
                end
                if (state_o == 3'd1 && prev_state != 3'd1) fetch_idx = i;
                if (instr_done_o === 1'b1) begin
                    total++;
                    if (lat_q.size() == 0) begin
                        bad++;
                        $display("FAIL latency vec[%0d] got=unexpected retire want=none", i);
                    end else begin
                        want_lat = lat_q.pop_front();
                        if (i - fetch_idx + 1 != want_lat) begin
                            bad++;
                            $display("FAIL latency vec[%0d] got=%0d want=%0d",
                                     i, i - fetch_idx + 1, want_lat);
                        end
                    end
                end
                prev_state = state_o;
            end
        end
        total++;
        if (lat_q.size() != 0) begin
            bad++;
            $display("FAIL retire_count got=%0d missing want=0 missing", lat_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
